// File: rtl/tail_lamp_pwm_driver_pkg.sv
// -----------------------------------------------------------------------------
// tail_light_pkg
// Shared definitions for the tail-light output stage: lamp count, the bit
// position of each lamp in the request / drive vectors, and the default PWM
// resolution.
// -----------------------------------------------------------------------------
package tail_light_pkg;

    localparam int NUM_LAMPS    = 6;

    // Bit positions inside lamp_req / lamp_pwm / lamp_steady.
    localparam int LAMP_LC      = 5;
    localparam int LAMP_LB      = 4;
    localparam int LAMP_LA      = 3;
    localparam int LAMP_RA      = 2;
    localparam int LAMP_RB      = 1;
    localparam int LAMP_RC      = 0;

    localparam int PWM_BITS_DEF = 8;

endpackage

// File: rtl/tail_lamp_pwm_driver_if.sv
// -----------------------------------------------------------------------------
// tail_lamp_pwm_driver_if
// Lamp request / drive bundle between the tail-light controller side and the
// PWM output stage.
//   lights       : headlights on (asynchronous to dimClk)
//   lamp_req     : per-lamp on-request, bit5..0 = Lc, Lb, La, Ra, Rb, Rc
//   lamp_pwm     : per-lamp PWM bulb drive, same bit order
//   period_start : one-cycle pulse at the start of every PWM period
//   lamp_steady  : per-lamp flag, level has reached its target
// master = controller side, slave = PWM driver.
// -----------------------------------------------------------------------------
interface tail_lamp_pwm_driver_if;
    import tail_light_pkg::*;

    logic                 lights;
    logic [NUM_LAMPS-1:0] lamp_req;
    logic [NUM_LAMPS-1:0] lamp_pwm;
    logic                 period_start;
    logic [NUM_LAMPS-1:0] lamp_steady;

    modport master (
        output lights,
        output lamp_req,
        input  lamp_pwm,
        input  period_start,
        input  lamp_steady
    );

    modport slave (
        input  lights,
        input  lamp_req,
        output lamp_pwm,
        output period_start,
        output lamp_steady
    );

endinterface

// File: rtl/tail_lamp_pwm_driver_channel.sv
// -----------------------------------------------------------------------------
// lamp_ramp_channel
// One bulb: selects the brightness target, ramps the level toward it once per
// PWM period with saturating steps, and compares against the shared counter.
// Ports:
//   dimClk, reset : clock, synchronous active-high reset
//   req_s         : synchronised on-request for this lamp
//   lights_s      : synchronised headlights-on
//   cnt           : shared free-running PWM counter
//   wrap          : high while cnt is at its maximum (level update edge)
//   pwm           : registered bulb drive
//   steady        : registered "level equals target"
// -----------------------------------------------------------------------------
module lamp_ramp_channel #(
    parameter int PWM_BITS  = 8,
    parameter int DIM_DUTY  = 32,
    parameter int RAMP_STEP = 16
) (
    input  logic                dimClk,
    input  logic                reset,
    input  logic                req_s,
    input  logic                lights_s,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                wrap,
    output logic                pwm,
    output logic                steady
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_DIM = PWM_BITS'(DIM_DUTY);
    localparam logic [PWM_BITS:0]   STEP_W  = (PWM_BITS+1)'(RAMP_STEP);

    logic [PWM_BITS-1:0] tgt;
    logic [PWM_BITS-1:0] lvl;

    // One ramp step toward tgt. Done one bit wider so cur+step and tgt+step
    // cannot wrap; the result is clamped to tgt so it never overshoots.
    function automatic logic [PWM_BITS-1:0] ramp_next(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] goal
    );
        logic [PWM_BITS:0] cur_w;
        logic [PWM_BITS:0] goal_w;
        logic [PWM_BITS:0] res_w;
        cur_w  = {1'b0, cur};
        goal_w = {1'b0, goal};
        res_w  = cur_w;
        if (cur_w < goal_w) begin
            res_w = ((cur_w + STEP_W) > goal_w) ? goal_w : (cur_w + STEP_W);
        end else if (cur_w > goal_w) begin
            res_w = (cur_w >= (goal_w + STEP_W)) ? (cur_w - STEP_W) : goal_w;
        end
        return res_w[PWM_BITS-1:0];
    endfunction

    // Request wins over parking light.
    always_comb begin
        tgt = '0;
        if (req_s) begin
            tgt = LVL_MAX;
        end else if (lights_s) begin
            tgt = LVL_DIM;
        end
    end

    always_ff @(posedge dimClk) begin
        if (reset) begin
            lvl    <= '0;
            pwm    <= 1'b0;
            steady <= 1'b1;
        end else begin
            if (wrap) begin
                lvl <= ramp_next(lvl, tgt);
            end
            // Full level is forced on so the bulb never blinks off at cnt==MAX.
            pwm    <= (lvl == LVL_MAX) | (cnt < lvl);
            steady <= (lvl == tgt);
        end
    end

endmodule

// File: rtl/tail_lamp_pwm_driver.sv
// -----------------------------------------------------------------------------
// tail_lamp_pwm_driver
// PWM output stage for the six tail lamps. Synchronises the lamp requests and
// the headlight flag into dimClk, runs the shared PWM counter, and hands each
// lamp to its own ramp channel.
// Ports:
//   dimClk : block clock
//   reset  : synchronous, active-high
//   bus    : lamp request / drive bundle (slave side), see
//            tail_lamp_pwm_driver_if
// -----------------------------------------------------------------------------
module tail_lamp_pwm_driver
    import tail_light_pkg::*;
#(
    parameter int PWM_BITS  = PWM_BITS_DEF,
    parameter int DIM_DUTY  = 32,
    parameter int RAMP_STEP = 16
) (
    input  logic                  dimClk,
    input  logic                  reset,
    tail_lamp_pwm_driver_if.slave bus
);

    logic [NUM_LAMPS-1:0] req_p0;
    logic [NUM_LAMPS-1:0] req_s;
    logic                 lights_p0;
    logic                 lights_s;
    logic [PWM_BITS-1:0]  cnt;
    logic                 wrap;
    logic                 period_start_r;
    logic [NUM_LAMPS-1:0] pwm_w;
    logic [NUM_LAMPS-1:0] steady_w;

    // Two-flop synchronisers; only the second stage is used downstream.
    always_ff @(posedge dimClk) begin
        if (reset) begin
            req_p0    <= '0;
            req_s     <= '0;
            lights_p0 <= 1'b0;
            lights_s  <= 1'b0;
        end else begin
            req_p0    <= bus.lamp_req;
            req_s     <= req_p0;
            lights_p0 <= bus.lights;
            lights_s  <= lights_p0;
        end
    end

    // Free-running PWM counter. period_start is registered from cnt==0, so
    // it is high while cnt==1, aligned with the first pwm output of a period.
    always_ff @(posedge dimClk) begin
        if (reset) begin
            cnt            <= '0;
            period_start_r <= 1'b0;
        end else begin
            cnt            <= cnt + PWM_BITS'(1);
            period_start_r <= (cnt == '0);
        end
    end

    assign wrap = &cnt;

    for (genvar i = 0; i < NUM_LAMPS; i++) begin : g_lamp
        lamp_ramp_channel #(
            .PWM_BITS  (PWM_BITS),
            .DIM_DUTY  (DIM_DUTY),
            .RAMP_STEP (RAMP_STEP)
        ) u_channel (
            .dimClk   (dimClk),
            .reset    (reset),
            .req_s    (req_s[i]),
            .lights_s (lights_s),
            .cnt      (cnt),
            .wrap     (wrap),
            .pwm      (pwm_w[i]),
            .steady   (steady_w[i])
        );
    end

    assign bus.lamp_pwm     = pwm_w;
    assign bus.lamp_steady  = steady_w;
    assign bus.period_start = period_start_r;

endmodule

// File: tb/tb_tail_lamp_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_tail_lamp_pwm_driver
// Scoreboard bench. Inputs change once per PWM period, right after
// period_start is seen; the reference model steps each lamp's brightness with
// plain integer arithmetic and queues the level expected in that period's
// window plus the steady flag expected at its end. The monitor collects each
// 256-cycle window, infers the level from the pwm pattern and compares.
// -----------------------------------------------------------------------------
module tb_tail_lamp_pwm_driver;
    import tail_light_pkg::*;

    localparam int PB   = 8;
    localparam int MAXL = 255;
    localparam int DIM  = 32;
    localparam int STEP = 16;
    localparam int PER  = 256;

    logic dimClk = 1'b0;
    logic reset  = 1'b1;

    tail_lamp_pwm_driver_if bus();

    tail_lamp_pwm_driver #(
        .PWM_BITS  (PB),
        .DIM_DUTY  (DIM),
        .RAMP_STEP (STEP)
    ) dut (
        .dimClk (dimClk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 dimClk = ~dimClk;

    typedef struct packed {
        logic [5:0]      steady;
        logic [5:0][8:0] lvl;
    } exp_t;

    exp_t expq[$];
    int   mlvl[6];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act == want) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    function automatic int tgt_of(input bit r, input bit l);
        if (r) return MAXL;
        if (l) return DIM;
        return 0;
    endfunction

    function automatic int step_to(input int cur, input int t);
        if (cur < t) return (cur + STEP > t) ? t : cur + STEP;
        if (cur > t) return (cur - STEP < t) ? t : cur - STEP;
        return cur;
    endfunction

    task automatic wait_ps();
        int n;
        n = 0;
        do begin
            @(negedge dimClk);
            n++;
        end while (!bus.period_start && n < 400);
        if (!bus.period_start) begin
            $display("FAIL period_start timeout: none in %0d cycles, expected within %0d", n, PER);
            $fatal(1, "no period_start");
        end
    endtask

    // Drives one input set per period and queues the model's expectation.
    task automatic stim(input int n, input int mode, input logic [5:0] rq,
                        input logic lt, input bit glitch);
        logic [5:0] r;
        logic       l;
        exp_t       e;
        r = rq;
        l = lt;
        for (int p = 0; p < n; p++) begin
            if (p > 0) wait_ps();
            if (mode == 1 && $urandom_range(2) == 0) begin
                r = 6'($urandom);
                l = 1'($urandom);
            end
            bus.lamp_req = r;
            bus.lights   = l;
            for (int i = 0; i < 6; i++) begin
                int t;
                t           = tgt_of(r[i], l);
                e.steady[i] = (mlvl[i] == t);
                e.lvl[i]    = 9'(mlvl[i]);
                mlvl[i]     = step_to(mlvl[i], t);
            end
            expq.push_back(e);
            if (glitch) begin
                repeat (50) @(negedge dimClk);
                bus.lamp_req[LAMP_LC] = 1'b1;
                repeat (10) @(negedge dimClk);
                bus.lamp_req[LAMP_LC] = r[LAMP_LC];
            end
        end
    endtask

    // Collects n windows starting at the current period_start sample.
    task automatic mon(input int n);
        logic [5:0] samp [PER];
        logic [5:0] last_st;
        int         k;
        exp_t       e;
        for (int p = 0; p < n; p++) begin
            samp[0] = bus.lamp_pwm;
            last_st = bus.lamp_steady;
            k = 1;
            while (1'b1) begin
                @(negedge dimClk);
                if (bus.period_start) break;
                if (k < PER) samp[k] = bus.lamp_pwm;
                last_st = bus.lamp_steady;
                k++;
                if (k > 400) begin
                    $display("FAIL period length: exceeded %0d cycles, expected %0d", k, PER);
                    $fatal(1, "period overrun");
                end
            end
            check("period length", k, PER);
            if (expq.size() == 0) begin
                check("scoreboard depth", 0, 1);
                continue;
            end
            e = expq.pop_front();
            for (int i = 0; i < 6; i++) begin
                int ex, hi, bad;
                ex  = int'(e.lvl[i]);
                hi  = 0;
                bad = 0;
                for (int c = 0; c < PER; c++) begin
                    bit want;
                    want = (ex == MAXL) || (c < ex);
                    if (samp[c][i]) hi++;
                    if (samp[c][i] != want) bad++;
                end
                checks++;
                if (bad == 0) passes++;
                else $display("FAIL lamp%0d pwm window: %0d high cycles (%0d misplaced), expected level %0d high from cnt 0",
                              i, hi, bad, ex);
                check($sformatf("lamp%0d steady", i), int'(last_st[i]), int'(e.steady[i]));
            end
        end
    endtask

    task automatic run(input int n, input int mode, input logic [5:0] rq,
                       input logic lt, input bit glitch);
        fork
            stim(n, mode, rq, lt, glitch);
            mon(n);
        join
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.lamp_req = '0;
        bus.lights   = 1'b0;
        for (int i = 0; i < 6; i++) mlvl[i] = 0;
        reset = 1'b1;
        repeat (3) @(negedge dimClk);
        check("reset lamp_pwm", int'(bus.lamp_pwm), 0);
        check("reset period_start", int'(bus.period_start), 0);
        check("reset lamp_steady", int'(bus.lamp_steady), 63);
        reset = 1'b0;
        wait_ps();

        // Idle, then ramp Lc up to 128 and reset in the middle of the ramp.
        run(2, 0, 6'b000000, 1'b0, 1'b0);
        run(8, 0, 6'b100000, 1'b0, 1'b0);
        repeat (20) @(negedge dimClk);
        check("Lc pwm at level 128 before reset", int'(bus.lamp_pwm[LAMP_LC]), 1);
        reset = 1'b1;
        @(negedge dimClk);
        check("mid reset lamp_pwm", int'(bus.lamp_pwm), 0);
        check("mid reset period_start", int'(bus.period_start), 0);
        check("mid reset lamp_steady", int'(bus.lamp_steady), 63);
        @(negedge dimClk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) mlvl[i] = 0;
        expq.delete();
        wait_ps();
        run(2, 0, 6'b100000, 1'b0, 1'b0);

        // Back to dark, then a short Lc pulse that must not move the level.
        run(3, 0, 6'b000000, 1'b0, 1'b0);
        run(2, 0, 6'b000000, 1'b0, 1'b1);

        // Parking, full on, release back to parking level.
        run(4, 0, 6'b000000, 1'b1, 1'b0);
        run(16, 0, 6'b111111, 1'b1, 1'b0);
        run(16, 0, 6'b000000, 1'b1, 1'b0);

        // Dark, then a single Rc ramp from 0 to full.
        run(3, 0, 6'b000000, 1'b0, 1'b0);
        run(18, 0, 6'b000001, 1'b0, 1'b0);

        // Random request / headlight changes.
        run(20, 1, 6'b000000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
